// File: rtl/tempo_pkg.sv
// Shared types and timing helpers for the beat-timing source and its key debouncers.
package tempo_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int BPM_W = 8;
  localparam int ACC_W = 32;

  // One beat lasts PERIOD/bpm clocks, so PERIOD is sixty seconds' worth of clocks.
  function automatic logic [ACC_W-1:0] period_of(input longint unsigned clk_hz);
    return ACC_W'(clk_hz * 64'd60);
  endfunction

  function automatic logic [ACC_W-1:0] half_of(input longint unsigned clk_hz);
    return period_of(clk_hz) >> 1;
  endfunction

endpackage

// File: rtl/tempo_gen_if.sv
// Key inputs and beat outputs of the tempo generator, grouped as one bundle.
interface tempo_gen_if;
  import tempo_pkg::*;

  logic             key_run;
  logic             key_up;
  logic             key_down;
  logic             new_clk;
  logic             beat_tick;
  logic [3:0]       beat_idx;
  logic [BPM_W-1:0] bpm;
  logic             running;

  modport master (
    input  key_run, key_up, key_down,
    output new_clk, beat_tick, beat_idx, bpm, running
  );

  modport slave (
    output key_run, key_up, key_down,
    input  new_clk, beat_tick, beat_idx, bpm, running
  );

endinterface

// File: rtl/tempo_gen_key_debounce.sv
// Turns a raw active-low board key into a single-cycle pulse per accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync0;
  logic             sync1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after it has differed from the held level for DEBOUNCE_CYC cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync0 <= key_n;
      sync1 <= sync0;
      press <= 1'b0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= sync1;
        press <= ~sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tempo_gen.sv
// Beat-timing source: key-adjustable BPM, run/stop control and a phase-accumulator beat clock.
module tempo_gen
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BPM_MIN      = 60,
  parameter int unsigned BPM_MAX      = 240,
  parameter int unsigned BPM_STEP     = 10,
  parameter int unsigned BPM_RESET    = 120,
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic        clock,
  input  logic        resetn,
  tempo_gen_if.master bus
);

  localparam logic [ACC_W-1:0] PERIOD  = period_of(CLK_HZ);
  localparam logic [ACC_W-1:0] HALF    = half_of(CLK_HZ);
  localparam logic [BPM_W-1:0] MIN_B   = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] MAX_B   = BPM_W'(BPM_MAX);
  localparam logic [BPM_W-1:0] STEP_B  = BPM_W'(BPM_STEP);
  localparam logic [BPM_W-1:0] RESET_B = BPM_W'(BPM_RESET);

  logic             run_p;
  logic             up_p;
  logic             down_p;
  state_t           state;
  logic [BPM_W-1:0] bpm_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             wrap;
  logic             new_clk_q;
  logic             beat_tick_q;
  logic [3:0]       beat_idx_q;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_run (
    .clock (clock),
    .resetn(resetn),
    .key_n (bus.key_run),
    .press (run_p)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
    .clock (clock),
    .resetn(resetn),
    .key_n (bus.key_up),
    .press (up_p)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_down (
    .clock (clock),
    .resetn(resetn),
    .key_n (bus.key_down),
    .press (down_p)
  );

  // Simultaneous up and down presses cancel; otherwise step and clamp to the tempo range.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bpm_q <= RESET_B;
    end else if (up_p && !down_p) begin
      bpm_q <= (bpm_q >= MAX_B - STEP_B) ? MAX_B : bpm_q + STEP_B;
    end else if (down_p && !up_p) begin
      bpm_q <= (bpm_q <= MIN_B + STEP_B) ? MIN_B : bpm_q - STEP_B;
    end
  end

  always_comb begin
    acc_sum  = acc + ACC_W'(bpm_q);
    wrap     = (acc_sum >= PERIOD);
    acc_next = wrap ? acc_sum - PERIOD : acc_sum;
  end

  // Starting plays the held step at once; stopping drops any tick due in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= STOPPED;
      acc         <= '0;
      new_clk_q   <= 1'b0;
      beat_tick_q <= 1'b0;
      beat_idx_q  <= '0;
    end else begin
      case (state)
        STOPPED: begin
          acc         <= '0;
          new_clk_q   <= 1'b0;
          beat_tick_q <= 1'b0;
          if (run_p) begin
            state       <= RUNNING;
            new_clk_q   <= 1'b1;
            beat_tick_q <= 1'b1;
          end
        end
        RUNNING: begin
          if (run_p) begin
            state       <= STOPPED;
            acc         <= '0;
            new_clk_q   <= 1'b0;
            beat_tick_q <= 1'b0;
          end else begin
            acc         <= acc_next;
            beat_tick_q <= wrap;
            new_clk_q   <= (acc_next < HALF);
            if (wrap) begin
              beat_idx_q <= beat_idx_q + 4'd1;
            end
          end
        end
        default: begin
          state <= STOPPED;
        end
      endcase
    end
  end

  assign bus.new_clk   = new_clk_q;
  assign bus.beat_tick = beat_tick_q;
  assign bus.beat_idx  = beat_idx_q;
  assign bus.bpm       = bpm_q;
  assign bus.running   = (state == RUNNING);

endmodule

// File: tb/tb_tempo_gen.sv
// Scoreboard bench for tempo_gen: expected beat gaps are queued per start and checked on each tick.
module tb_tempo_gen;
  import tempo_pkg::*;

  localparam int CLK_HZ = 100;
  localparam int DEB    = 4;
  localparam int PERIOD = 6000;
  localparam int HALF   = 3000;

  typedef struct {
    int gap;
    int high;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  tempo_gen_if bus();

  tempo_gen #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t   sbq[$];
  int     checks    = 0;
  int     failures  = 0;
  bit     scoreOn   = 1'b0;
  int     startReq  = 0;
  int     startSeen = 0;
  int     modelIdx  = 0;
  longint cyc       = 0;
  longint lastTick  = 0;
  int     highCnt   = 0;

  task automatic checkOutput(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int ceilDiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Beat index model: a start tick replays the held step, every other tick advances it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin
        modelIdx = 0;
        highCnt  = 0;
        lastTick = cyc;
      end else if (bus.beat_tick) begin
        if (startReq != startSeen) startSeen = startReq;
        else modelIdx = (modelIdx + 1) % 16;
        checkOutput("beat_idx", bus.beat_idx, modelIdx);
        if (scoreOn) begin
          if (sbq.size() == 0) begin
            checkOutput("extra_tick", 1, 0);
          end else begin
            e = sbq.pop_front();
            if (e.gap >= 0)  checkOutput("beat_gap", cyc - lastTick, e.gap);
            if (e.high >= 0) checkOutput("new_clk_high", highCnt, e.high);
          end
        end
        lastTick = cyc;
        highCnt  = int'(bus.new_clk);
      end else begin
        highCnt += int'(bus.new_clk);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setKey(input int k, input logic v);
    case (k)
      0:       bus.key_run = v;
      1:       bus.key_up  = v;
      2:       bus.key_down = v;
      default: begin
        bus.key_up   = v;
        bus.key_down = v;
      end
    endcase
  endtask

  // k: 0 run, 1 up, 2 down, 3 up and down together.
  task automatic applyStimulus(input int k);
    @(negedge clock);
    setKey(k, 1'b0);
    repeat (10) @(negedge clock);
    setKey(k, 1'b1);
    repeat (10) @(negedge clock);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    scoreOn = 1'b0;
    @(negedge clock);
  endtask

  // From STOPPED, acc starts at 0, so tick k lands ceil(k*PERIOD/bpm) cycles after the start tick.
  task automatic startAndCheck(input int b, input int nBeats);
    exp_t e;
    e.gap  = -1;
    e.high = -1;
    sbq.push_back(e);
    for (int k = 1; k <= nBeats; k++) begin
      e.gap  = ceilDiv(PERIOD * k, b) - ceilDiv(PERIOD * (k - 1), b);
      e.high = (PERIOD % b == 0) ? ceilDiv(HALF, b) : -1;
      sbq.push_back(e);
    end
    scoreOn = 1'b1;
    startReq++;
    applyStimulus(0);
    waitDrain(nBeats * 120 + 200);
    checkOutput("running_on", bus.running, 1);
  endtask

  task automatic stopRun();
    applyStimulus(0);
    checkOutput("running_off", bus.running, 0);
    checkOutput("new_clk_off", bus.new_clk, 0);
  endtask

  initial begin
    int n;
    int quietTicks;
    int quietHigh;

    bus.key_run  = 1'b1;
    bus.key_up   = 1'b1;
    bus.key_down = 1'b1;
    resetn       = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_running", bus.running, 0);
    checkOutput("rst_bpm", bus.bpm, 120);
    checkOutput("rst_beat_idx", bus.beat_idx, 0);
    checkOutput("rst_new_clk", bus.new_clk, 0);
    checkOutput("rst_beat_tick", bus.beat_tick, 0);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("idle_bpm", bus.bpm, 120);
    checkOutput("idle_running", bus.running, 0);

    $display("[TB] start at 120 bpm, 17 beats");
    startAndCheck(120, 17);

    $display("[TB] bouncing up key");
    for (int i = 0; i < 10; i++) begin
      setKey(1, i[0]);
      repeat (2) @(negedge clock);
    end
    setKey(1, 1'b0);
    repeat (10) @(negedge clock);
    setKey(1, 1'b1);
    repeat (10) @(negedge clock);
    checkOutput("bounce_bpm", bus.bpm, 130);
    stopRun();
    startAndCheck(130, 13);

    $display("[TB] saturation");
    repeat (20) applyStimulus(1);
    checkOutput("bpm_ceiling", bus.bpm, 240);
    stopRun();
    startAndCheck(240, 4);
    repeat (30) applyStimulus(2);
    checkOutput("bpm_floor", bus.bpm, 60);
    stopRun();
    startAndCheck(60, 3);

    $display("[TB] simultaneous up and down");
    applyStimulus(1);
    checkOutput("bpm_up_one", bus.bpm, 70);
    applyStimulus(3);
    checkOutput("bpm_both", bus.bpm, 70);

    $display("[TB] stop at step 5 and restart");
    repeat (5) applyStimulus(1);
    checkOutput("bpm_back", bus.bpm, 120);
    n = 0;
    while (modelIdx == 5 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    while (modelIdx != 5 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idx5_reached", modelIdx, 5);
    stopRun();
    checkOutput("stop_beat_idx", bus.beat_idx, 5);
    quietTicks = 0;
    quietHigh  = 0;
    repeat (200) begin
      @(negedge clock);
      quietTicks += int'(bus.beat_tick);
      quietHigh  += int'(bus.new_clk);
    end
    checkOutput("stopped_ticks", quietTicks, 0);
    checkOutput("stopped_new_clk", quietHigh, 0);
    startAndCheck(120, 1);
    checkOutput("restart_idx", bus.beat_idx, 6);

    $display("[TB] asynchronous reset mid-beat");
    applyStimulus(1);
    checkOutput("pre_reset_bpm", bus.bpm, 130);
    checkOutput("pre_reset_running", bus.running, 1);
    repeat (20) @(negedge clock);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst_running", bus.running, 0);
    checkOutput("arst_bpm", bus.bpm, 120);
    checkOutput("arst_beat_idx", bus.beat_idx, 0);
    checkOutput("arst_new_clk", bus.new_clk, 0);
    checkOutput("arst_beat_tick", bus.beat_tick, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("post_reset_running", bus.running, 0);
    checkOutput("post_reset_bpm", bus.bpm, 120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
